// File: rtl/intr_ctrl_if.sv
// -----------------------------------------------------------------------------
// intr_ctrl_if
// Data-memory IO bus as seen by the interrupt controller register block.
//   addr   32  byte address of the access
//   wdata  32  write data
//   we      1  write strobe (one cycle per write)
//   rd      1  read strobe (data returned registered, one cycle later)
//   rdata  32  registered read data from the slave
// master: the CPU/bus side. slave: the interrupt controller.
// -----------------------------------------------------------------------------
interface intr_ctrl_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        rd;
    logic [31:0] rdata;

    modport master (
        output addr,
        output wdata,
        output we,
        output rd,
        input  rdata
    );

    modport slave (
        input  addr,
        input  wdata,
        input  we,
        input  rd,
        output rdata
    );
endinterface

// File: rtl/intr_ctrl.sv
// -----------------------------------------------------------------------------
// intr_ctrl
// Interrupt responder for the multicycle OTTER control unit. External request
// lines are synchronised, turned into pending bits, masked and prioritised
// (lowest index wins). A single registered intr line is raised towards the CU;
// the int_taken / mret_exec pulses walk a three-state handshake
// (IDLE -> ASSERT -> ACTIVE -> IDLE).
//
// Register block at IO_BASE (word offsets):
//   +0  MASK   RW  [N_SRC-1:0]
//   +4  PEND   RO, write-1-to-clear
//   +8  CAUSE  RO  {valid [31], id [3:0]}
//   any other address reads 0, writes are ignored; unused upper bits read 0.
//
// Ports:
//   clk           system clock
//   RST           synchronous, active-high reset
//   i_src         asynchronous request lines from peripherals
//   i_int_taken   one-cycle pulse from the CU in its interrupt state
//   i_mret_exec   one-cycle pulse from the CU when mret executes
//   bus           IO bus slave (addr, wdata, we, rd, registered rdata)
//   o_intr        interrupt request to the CU (MIE gating is done in the CU)
//   o_isr_active  high while an interrupt service routine is in progress
//
// Configuration macro INTR_LEVEL_MODE_EN:
//   defined   - level mode: pending mirrors the synchronised request lines,
//               W1C and claim-clear have no effect.
//   undefined - edge mode (default): rising edges latch pending bits.
// -----------------------------------------------------------------------------
module intr_ctrl #(
    parameter int          N_SRC   = 8,
    parameter logic [31:0] IO_BASE = 32'h1100_0100
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [N_SRC-1:0] i_src,
    input  logic             i_int_taken,
    input  logic             i_mret_exec,
    intr_ctrl_if.slave       bus,
    output logic             o_intr,
    output logic             o_isr_active
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    // Lowest set index of a request vector; 0 when the vector is empty.
    function automatic logic [3:0] f_lowest_set(input logic [N_SRC-1:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            idx = v[i] ? 4'(i) : idx;
        end
        return idx;
    endfunction

    // ---------------------------------------------------------------- signals
    logic [N_SRC-1:0] r_sync1;
    logic [N_SRC-1:0] r_sync2;
    logic [N_SRC-1:0] w_pending;
    logic [N_SRC-1:0] r_mask;
    logic [N_SRC-1:0] w_req;
    logic             w_any_req;
    logic [3:0]       w_winner;
    logic             w_claim;
    logic             w_mret;
    logic             r_cause_valid;
    logic [3:0]       r_cause_id;
    logic             w_sel_mask;
    logic             w_sel_pend;
    logic             w_sel_cause;
    logic [31:0]      w_rd_val;
    logic [31:0]      r_rdata;
    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_intr;
    logic             r_isr_active;
    logic             w_unused_bits;

`ifndef INTR_LEVEL_MODE_EN
    logic [N_SRC-1:0] r_sync3;
    logic [N_SRC-1:0] r_pending;
    logic [N_SRC-1:0] w_edge;
    logic [N_SRC-1:0] w_clr_vec;
    logic [N_SRC-1:0] w_claim_vec;
`endif

    // ------------------------------------------------------- address decode
    assign w_sel_mask  = (bus.addr == IO_BASE);
    assign w_sel_pend  = (bus.addr == (IO_BASE + 32'd4));
    assign w_sel_cause = (bus.addr == (IO_BASE + 32'd8));

    // Upper write-data bits have no destination in this block.
    assign w_unused_bits = ^bus.wdata;

    // Two-flop synchroniser for the asynchronous request lines.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_sync1 <= {N_SRC{1'b0}};
            r_sync2 <= {N_SRC{1'b0}};
        end else begin
            r_sync1 <= i_src;
            r_sync2 <= r_sync1;
        end
    end

`ifndef INTR_LEVEL_MODE_EN
    // Third flop: previous synchronised value for rising-edge detection.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_sync3 <= {N_SRC{1'b0}};
        end else begin
            r_sync3 <= r_sync2;
        end
    end

    assign w_edge      = r_sync2 & ~r_sync3;
    assign w_clr_vec   = (bus.we && w_sel_pend) ? bus.wdata[N_SRC-1:0] : {N_SRC{1'b0}};
    assign w_claim_vec = w_claim ? (N_SRC'(1) << w_winner) : {N_SRC{1'b0}};

    // Pending latch: a new edge overrides a same-cycle W1C or claim clear.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_pending <= {N_SRC{1'b0}};
        end else begin
            r_pending <= (r_pending & ~w_clr_vec & ~w_claim_vec) | w_edge;
        end
    end

    assign w_pending = r_pending;
`else
    // Level mode: pending is simply the synchronised line.
    assign w_pending = r_sync2;
`endif

    // ------------------------------------------------------- arbitration
    // r_mask is the pre-write value, so a claim coinciding with a MASK write
    // arbitrates with the old mask.
    assign w_req     = w_pending & r_mask;
    assign w_any_req = |w_req;
    assign w_winner  = f_lowest_set(w_req);
    assign w_mret    = (r_state == ST_ACTIVE) && i_mret_exec;

    // MASK register write.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_mask <= {N_SRC{1'b0}};
        end else if (bus.we && w_sel_mask) begin
            r_mask <= bus.wdata[N_SRC-1:0];
        end else begin
            r_mask <= r_mask;
        end
    end

    // CAUSE register: loaded on a claim, cleared when the ISR returns.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_cause_valid <= 1'b0;
            r_cause_id    <= 4'd0;
        end else if (w_claim) begin
            r_cause_valid <= 1'b1;
            r_cause_id    <= w_winner;
        end else if (w_mret) begin
            r_cause_valid <= 1'b0;
            r_cause_id    <= 4'd0;
        end else begin
            r_cause_valid <= r_cause_valid;
            r_cause_id    <= r_cause_id;
        end
    end

    // Read mux for the register block.
    always_comb begin
        w_rd_val = 32'd0;
        if (w_sel_mask) begin
            w_rd_val = 32'(r_mask);
        end else if (w_sel_pend) begin
            w_rd_val = 32'(w_pending);
        end else if (w_sel_cause) begin
            w_rd_val = {r_cause_valid, 27'd0, r_cause_id};
        end else begin
            w_rd_val = 32'd0;
        end
    end

    // Registered read data: updates only on a read strobe.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_rdata <= 32'd0;
        end else if (bus.rd) begin
            r_rdata <= w_rd_val;
        end else begin
            r_rdata <= r_rdata;
        end
    end

    assign bus.rdata = r_rdata;

    // Handshake FSM next-state. int_taken outside ASSERT and mret_exec
    // outside ACTIVE fall through to "stay". A take with nothing left to
    // claim still enters ACTIVE because the CU has already vectored.
    always_comb begin
        w_state_nxt = r_state;
        w_claim     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_ASSERT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ASSERT: begin
                if (i_int_taken) begin
                    w_state_nxt = ST_ACTIVE;
                    w_claim     = w_any_req;
                end else if (!w_any_req) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_ASSERT;
                end
            end
            ST_ACTIVE: begin
                if (i_mret_exec) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register with registered output decodes (glitch-free intr).
    always_ff @(posedge clk) begin
        if (RST) begin
            r_state      <= ST_IDLE;
            r_intr       <= 1'b0;
            r_isr_active <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_intr       <= (w_state_nxt == ST_ASSERT);
            r_isr_active <= (w_state_nxt == ST_ACTIVE);
        end
    end

    assign o_intr       = r_intr;
    assign o_isr_active = r_isr_active;

endmodule

// File: tb/tb_intr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_intr_ctrl
// Self-checking bench for intr_ctrl (N_SRC = 8). A behavioural model tracks
// the register contents and the request/service phase every clock; directed
// scenarios are followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_intr_ctrl;

    localparam logic [31:0] BASE = 32'h1100_0100;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] src;
    logic       taken;
    logic       mret;
    logic       o_intr;
    logic       o_isr_active;

    intr_ctrl_if u_bus ();

    intr_ctrl #(.N_SRC(8), .IO_BASE(BASE)) u_dut (
        .clk          (clk),
        .RST          (rst),
        .i_src        (src),
        .i_int_taken  (taken),
        .i_mret_exec  (mret),
        .bus          (u_bus.slave),
        .o_intr       (o_intr),
        .o_isr_active (o_isr_active)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state. phase: 0 = no request, 1 = request raised, 2 = in ISR.
    // dly[k] is the request vector as seen k+1 clocks after sampling.
    logic [7:0]  m_mask;
    logic [7:0]  m_pend;
    logic [7:0]  dly [3];
    int          m_phase;
    logic        m_cv;
    logic [3:0]  m_cid;
    logic [31:0] m_rdata;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs presented to the DUT.
    task automatic model_clock();
        logic [7:0]  req;
        logic [7:0]  clr;
        logic [7:0]  claim;
        logic [31:0] rv;
        int          win;
        if (rst) begin
            m_mask = 8'h00; m_pend = 8'h00; m_phase = 0;
            m_cv = 1'b0; m_cid = 4'd0; m_rdata = 32'd0;
            for (int k = 0; k < 3; k++) dly[k] = 8'h00;
        end else begin
            req = m_pend & m_mask;
            win = -1;
            for (int i = 7; i >= 0; i--) if (req[i]) win = i;

            rv = 32'd0;
            if (u_bus.addr == BASE)              rv = {24'd0, m_mask};
            else if (u_bus.addr == BASE + 32'd4) rv = {24'd0, m_pend};
            else if (u_bus.addr == BASE + 32'd8) rv = {m_cv, 27'd0, m_cid};
            if (u_bus.rd) m_rdata = rv;

            clr   = (u_bus.we && u_bus.addr == BASE + 32'd4) ? u_bus.wdata[7:0] : 8'h00;
            claim = 8'h00;
            case (m_phase)
                0: if (req != 8'h00) m_phase = 1;
                1: begin
                    if (taken) begin
                        m_phase = 2;
                        if (win >= 0) begin
                            claim[win] = 1'b1;
                            m_cv  = 1'b1;
                            m_cid = 4'(win);
                        end
                    end else if (req == 8'h00) begin
                        m_phase = 0;
                    end
                end
                default: if (mret) begin
                    m_phase = 0; m_cv = 1'b0; m_cid = 4'd0;
                end
            endcase
`ifndef INTR_LEVEL_MODE_EN
            m_pend = (m_pend & ~clr & ~claim) | (dly[1] & ~dly[2]);
`else
            m_pend = dly[0];
`endif
            if (u_bus.we && u_bus.addr == BASE) m_mask = u_bus.wdata[7:0];
            dly[2] = dly[1];
            dly[1] = dly[0];
            dly[0] = src;
        end
    endtask

    // One clock: update the model at the edge, compare outputs 1 ns later.
    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
        check_eq("intr", {31'd0, o_intr}, {31'd0, (m_phase == 1)});
        check_eq("isr_active", {31'd0, o_isr_active}, {31'd0, (m_phase == 2)});
        check_eq("rdata", u_bus.rdata, m_rdata);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        u_bus.addr = a; u_bus.wdata = d; u_bus.we = 1'b1;
        step();
        u_bus.we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        u_bus.addr = a; u_bus.rd = 1'b1;
        step();
        u_bus.rd = 1'b0;
        d = u_bus.rdata;
    endtask

    task automatic pulse_src(input logic [7:0] v);
        src = v;
        step();
        src = 8'h00;
    endtask

    task automatic pulse_taken();
        taken = 1'b1; step(); taken = 1'b0;
    endtask

    task automatic pulse_mret();
        mret = 1'b1; step(); mret = 1'b0;
    endtask

    task automatic wait_intr(input string tag, input int budget);
        int n;
        n = 0;
        while (o_intr !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check_eq(tag, {31'd0, o_intr}, 32'd1);
    endtask

    logic [31:0] rd_v;
    logic [7:0]  off_sel;

    initial begin
        rst = 1'b1; src = 8'h00; taken = 1'b0; mret = 1'b0;
        u_bus.addr = 32'd0; u_bus.wdata = 32'd0; u_bus.we = 1'b0; u_bus.rd = 1'b0;
        m_mask = 8'h00; m_pend = 8'h00; m_phase = 0; m_cv = 1'b0; m_cid = 4'd0;
        m_rdata = 32'd0;
        for (int k = 0; k < 3; k++) dly[k] = 8'h00;

        step(); step();
        check_eq("rst_intr", {31'd0, o_intr}, 32'd0);
        check_eq("rst_isr", {31'd0, o_isr_active}, 32'd0);
        rst = 1'b0;
        step();

`ifndef INTR_LEVEL_MODE_EN
        // 1: single source, full handshake
        bus_write(BASE, 32'h01);
        pulse_src(8'h01);
        wait_intr("t1_intr", 6);
        pulse_taken();
        check_eq("t1_intr_drop", {31'd0, o_intr}, 32'd0);
        bus_read(BASE + 32'd8, rd_v); check_eq("t1_cause", rd_v, 32'h8000_0000);
        bus_read(BASE + 32'd4, rd_v); check_eq("t1_pend", rd_v, 32'h0);
        pulse_mret();
        check_eq("t1_isr_end", {31'd0, o_isr_active}, 32'd0);
        bus_read(BASE + 32'd8, rd_v); check_eq("t1_cause_clr", rd_v, 32'h0);

        // 2: simultaneous edges, lowest index first
        bus_write(BASE, 32'hFF);
        pulse_src(8'h24);
        wait_intr("t2_intr", 6);
        pulse_taken();
        bus_read(BASE + 32'd8, rd_v); check_eq("t2_cause_a", rd_v, 32'h8000_0002);
        pulse_mret();
        wait_intr("t2_rearm", 2);
        pulse_taken();
        bus_read(BASE + 32'd8, rd_v); check_eq("t2_cause_b", rd_v, 32'h8000_0005);
        pulse_mret();

        // 3: masked source stays pending until unmasked
        bus_write(BASE, 32'h00);
        pulse_src(8'h08);
        for (int i = 0; i < 5; i++) step();
        check_eq("t3_no_intr", {31'd0, o_intr}, 32'd0);
        bus_read(BASE + 32'd4, rd_v); check_eq("t3_pend", rd_v, 32'h08);
        bus_write(BASE, 32'h08);
        wait_intr("t3_intr", 3);
        pulse_taken();
        pulse_mret();

        // 4: W1C withdraws a raised request
        bus_write(BASE, 32'h02);
        pulse_src(8'h02);
        wait_intr("t4_intr", 6);
        bus_write(BASE + 32'd4, 32'h02);
        step();
        check_eq("t4_intr_drop", {31'd0, o_intr}, 32'd0);
        bus_read(BASE + 32'd4, rd_v); check_eq("t4_pend", rd_v, 32'h0);

        // 5: reset in the middle of an ISR
        bus_write(BASE, 32'hFF);
        pulse_src(8'h31);
        wait_intr("t5_intr", 6);
        pulse_taken();
        bus_read(BASE + 32'd4, rd_v); check_eq("t5_pend", rd_v, 32'h30);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("t5_intr", {31'd0, o_intr}, 32'd0);
        check_eq("t5_isr", {31'd0, o_isr_active}, 32'd0);
        bus_read(BASE, rd_v);          check_eq("t5_mask", rd_v, 32'h0);
        bus_read(BASE + 32'd4, rd_v);  check_eq("t5_pend0", rd_v, 32'h0);
        bus_read(BASE + 32'd8, rd_v);  check_eq("t5_cause", rd_v, 32'h0);
`else
        // 6: level mode, held line re-raises after mret, dropped line does not
        bus_write(BASE, 32'h10);
        src = 8'h10;
        wait_intr("t6_intr", 6);
        pulse_taken();
        step();
        pulse_mret();
        wait_intr("t6_rearm", 3);
        pulse_taken();
        src = 8'h00;
        for (int i = 0; i < 3; i++) step();
        pulse_mret();
        for (int i = 0; i < 3; i++) step();
        check_eq("t6_idle", {31'd0, o_intr}, 32'd0);
        check_eq("t6_isr", {31'd0, o_isr_active}, 32'd0);
`endif

        // Randomized run
        bus_write(BASE, {24'd0, 8'($urandom)});
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 5) == 0) src = src ^ (8'd1 << $urandom_range(0, 7));
            taken = (o_intr && $urandom_range(0, 2) == 0) || ($urandom_range(0, 30) == 0);
            mret  = (o_isr_active && $urandom_range(0, 3) == 0) || ($urandom_range(0, 30) == 0);
            rst   = ($urandom_range(0, 400) == 0);
            u_bus.we = 1'b0; u_bus.rd = 1'b0;
            off_sel = 8'($urandom_range(0, 5));
            u_bus.addr  = (off_sel == 8'd5) ? BASE + 32'd16 : BASE + {22'd0, off_sel, 2'b00};
            u_bus.wdata = $urandom;
            case ($urandom_range(0, 9))
                0: begin u_bus.we = 1'b1; u_bus.addr = BASE; end
                1: begin u_bus.we = 1'b1; u_bus.addr = BASE + 32'd4; end
                2, 3, 4: u_bus.rd = 1'b1;
                5: u_bus.we = 1'b1;
                default: ;
            endcase
            step();
        end
        rst = 1'b0; taken = 1'b0; mret = 1'b0; u_bus.we = 1'b0; u_bus.rd = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
